// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module   : regfile_wb_arbiter
// Brief    : Register-file write-port arbiter between the pipeline write-back
//            and a small queue of multi-cycle (div/mult) results.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    input  logic        mc_valid,
    input  logic [4:0]  mc_waddr,
    input  logic [31:0] mc_wdata,
    output logic        mc_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] pend_mask,
    output logic        stall_req
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [2:0]  C_STARVE_MAX = 3'(STARVE_MAX);

    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       starve_q, starve_d;
    logic             stall_q, stall_d;

    logic head_live, push, pop, wb_kill, not_full;

    assign not_full  = (count_q != CNT_W'(DEPTH));
    assign head_live = (count_q != '0) && live_q[head_q];
    assign mc_ready  = !rst && not_full;
    assign push      = mc_valid && mc_ready && (mc_waddr != 5'd0);
    // A dead head drains immediately; a live head only when wb is idle.
    assign pop       = !rst && (count_q != '0) && (!live_q[head_q] || !wb_we);
    assign wb_kill   = wb_we && (wb_waddr != 5'd0);
    assign stall_req = stall_q;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (!rst) begin
            if (wb_we) begin
                rf_we    = 1'b1;
                rf_waddr = wb_waddr;
                rf_wdata = wb_wdata;
            end else if (head_live) begin
                rf_we    = 1'b1;
                rf_waddr = addr_q[head_q];
                rf_wdata = data_q[head_q];
            end
        end
    end

    always_comb begin
        pend_mask = 32'd0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (live_q[i]) pend_mask[addr_q[i]] = 1'b1;
        end
        if (rst) pend_mask = 32'd0;
    end

    always_comb begin
        live_d = live_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (wb_kill && (addr_q[i] == wb_waddr)) live_d[i] = 1'b0;
        end
        if (pop)  live_d[head_q] = 1'b0;
        // The incoming mc result is newer than a same-cycle wb write.
        if (push) live_d[tail_q] = 1'b1;

        head_d  = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        starve_d = starve_q;
        if ((live_q == '0) || (head_live && !wb_we)) begin
            starve_d = 3'd0;
        end else if (head_live && wb_we && (starve_q != C_STARVE_MAX)) begin
            starve_d = starve_q + 3'd1;
        end
        stall_d = (starve_q == C_STARVE_MAX) && head_live;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            starve_q <= 3'd0;
            stall_q  <= 1'b0;
        end else begin
            live_q   <= live_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= mc_waddr;
            data_q[tail_q] <= mc_wdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Brief    : Directed self-checking bench for regfile_wb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        mc_valid;
    logic [4:0]  mc_waddr;
    logic [31:0] mc_wdata;
    logic        mc_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pend_mask;
    logic        stall_req;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DEPTH(2), .STARVE_MAX(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_we     (wb_we),
        .wb_waddr  (wb_waddr),
        .wb_wdata  (wb_wdata),
        .mc_valid  (mc_valid),
        .mc_waddr  (mc_waddr),
        .mc_wdata  (mc_wdata),
        .mc_ready  (mc_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .pend_mask (pend_mask),
        .stall_req (stall_req)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
        wb_we = we; wb_waddr = a; wb_wdata = d;
    endtask

    task automatic mc(input logic v, input logic [4:0] a, input logic [31:0] d);
        mc_valid = v; mc_waddr = a; mc_wdata = d;
    endtask

    initial begin
        rst = 1'b1;
        wb(1'b1, 5'd4, 32'hDEAD_BEEF);
        mc(1'b1, 5'd6, 32'h1111_1111);
        tick(); tick();
        #1;
        chk("rst_mc_ready", {31'd0, mc_ready}, 32'd0);
        chk("rst_rf_we",    {31'd0, rf_we}, 32'd0);
        chk("rst_rf_waddr", {27'd0, rf_waddr}, 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_pend",     pend_mask, 32'd0);
        chk("rst_stall",    {31'd0, stall_req}, 32'd0);

        rst = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        mc(1'b0, 5'd0, 32'd0);
        #1;
        chk("post_rst_ready", {31'd0, mc_ready}, 32'd1);
        chk("post_rst_pend",  pend_mask, 32'd0);

        // Single mc result, wb idle
        tick();
        mc(1'b1, 5'd5, 32'hA5A5_A5A5);
        #1;
        chk("s1_no_we", {31'd0, rf_we}, 32'd0);
        tick();
        mc(1'b0, 5'd0, 32'd0);
        #1;
        chk("s1_we",    {31'd0, rf_we}, 32'd1);
        chk("s1_waddr", {27'd0, rf_waddr}, 32'd5);
        chk("s1_wdata", rf_wdata, 32'hA5A5_A5A5);
        chk("s1_pend",  pend_mask, 32'h0000_0020);
        tick();
        #1;
        chk("s1_after_we",   {31'd0, rf_we}, 32'd0);
        chk("s1_after_pend", pend_mask, 32'd0);

        // mc result to r0 is swallowed
        mc(1'b1, 5'd0, 32'h0000_0123);
        tick();
        mc(1'b0, 5'd0, 32'd0);
        #1;
        chk("r0_we",    {31'd0, rf_we}, 32'd0);
        chk("r0_pend",  pend_mask, 32'd0);
        chk("r0_ready", {31'd0, mc_ready}, 32'd1);

        // Starvation under continuous wb writes
        wb(1'b1, 5'd3, 32'h0000_0033);
        mc(1'b1, 5'd7, 32'h0000_0077);
        #1;
        chk("s2_wb_wins", {27'd0, rf_waddr}, 32'd3);
        tick();
        mc(1'b1, 5'd8, 32'h0000_0088);
        #1;
        chk("s2_ready1", {31'd0, mc_ready}, 32'd1);
        chk("s2_pend1",  pend_mask, 32'h0000_0080);
        tick();
        mc(1'b0, 5'd0, 32'd0);
        #1;
        chk("s2_full",   {31'd0, mc_ready}, 32'd0);
        chk("s2_pend2",  pend_mask, 32'h0000_0180);
        chk("s2_wdata",  rf_wdata, 32'h0000_0033);
        chk("s2_stall1", {31'd0, stall_req}, 32'd0);
        tick();
        #1;
        chk("s2_stall2", {31'd0, stall_req}, 32'd0);
        tick();
        #1;
        chk("s2_stall3", {31'd0, stall_req}, 32'd0);
        tick();
        #1;
        chk("s2_stall4", {31'd0, stall_req}, 32'd1);
        wb(1'b0, 5'd0, 32'd0);
        #1;
        chk("s2_w7_addr", {27'd0, rf_waddr}, 32'd7);
        chk("s2_w7_data", rf_wdata, 32'h0000_0077);
        tick();
        #1;
        chk("s2_w8_addr", {27'd0, rf_waddr}, 32'd8);
        chk("s2_w8_data", rf_wdata, 32'h0000_0088);
        chk("s2_w8_ready", {31'd0, mc_ready}, 32'd1);
        chk("s2_w8_pend", pend_mask, 32'h0000_0100);
        tick();
        #1;
        chk("s2_done_we",    {31'd0, rf_we}, 32'd0);
        chk("s2_done_stall", {31'd0, stall_req}, 32'd0);

        // Queued entry killed by a newer wb write to the same register
        mc(1'b1, 5'd9, 32'h0000_0099);
        tick();
        mc(1'b0, 5'd0, 32'd0);
        wb(1'b1, 5'd9, 32'h0000_1234);
        #1;
        chk("s3_wb_data", rf_wdata, 32'h0000_1234);
        chk("s3_pend",    pend_mask, 32'h0000_0200);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        #1;
        chk("s3_killed_pend", pend_mask, 32'd0);
        chk("s3_no_write",    {31'd0, rf_we}, 32'd0);
        tick();
        #1;
        chk("s3_no_write2", {31'd0, rf_we}, 32'd0);
        chk("s3_ready",     {31'd0, mc_ready}, 32'd1);

        // Same-cycle enqueue and matching wb: the mc entry survives
        mc(1'b1, 5'd10, 32'h0000_00AA);
        wb(1'b1, 5'd10, 32'h0000_5555);
        tick();
        mc(1'b0, 5'd0, 32'd0);
        wb(1'b0, 5'd0, 32'd0);
        #1;
        chk("s4_addr", {27'd0, rf_waddr}, 32'd10);
        chk("s4_data", rf_wdata, 32'h0000_00AA);
        tick();

        // Simultaneous enqueue and pop on a non-full queue
        mc(1'b1, 5'd14, 32'h0000_0014);
        tick();
        mc(1'b1, 5'd15, 32'h0000_0015);
        #1;
        chk("s5_pop14", {27'd0, rf_waddr}, 32'd14);
        tick();
        mc(1'b0, 5'd0, 32'd0);
        #1;
        chk("s5_pop15",  rf_wdata, 32'h0000_0015);
        chk("s5_ready",  {31'd0, mc_ready}, 32'd1);
        tick();

        // Reset with two live entries queued
        wb(1'b1, 5'd1, 32'h0000_0001);
        mc(1'b1, 5'd11, 32'h0000_0B0B);
        tick();
        mc(1'b1, 5'd12, 32'h0000_0C0C);
        tick();
        mc(1'b1, 5'd13, 32'h0000_0D0D);
        #1;
        chk("s6_pend", pend_mask, 32'h0000_1800);
        rst = 1'b1;
        #1;
        chk("s6_rst_we",    {31'd0, rf_we}, 32'd0);
        chk("s6_rst_waddr", {27'd0, rf_waddr}, 32'd0);
        chk("s6_rst_wdata", rf_wdata, 32'd0);
        chk("s6_rst_ready", {31'd0, mc_ready}, 32'd0);
        chk("s6_rst_pend",  pend_mask, 32'd0);
        tick();
        rst = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        mc(1'b0, 5'd0, 32'd0);
        #1;
        chk("s6_ready", {31'd0, mc_ready}, 32'd1);
        chk("s6_pend2", pend_mask, 32'd0);
        chk("s6_we",    {31'd0, rf_we}, 32'd0);
        tick();
        #1;
        chk("s6_no_stale", {31'd0, rf_we}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning the number of entries in the multi-cycle write queue (power of 2, minimum 2).
REQ-002 The block SHALL have parameter STARVE_MAX, default 3, meaning the number of consecutive ungranted cycles after which a stall is requested.
REQ-003 The block SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port wb_we  input  1  pipeline write-back write enable (high priority, never back-pressured).
REQ-006 The block SHALL have port wb_waddr  input  5  pipeline write-back register address.
REQ-007 The block SHALL have port wb_wdata  input  32  pipeline write-back data.
REQ-008 The block SHALL have port mc_valid  input  1  multi-cycle unit (div/mult) result valid.
REQ-009 The block SHALL have port mc_waddr  input  5  multi-cycle result register address.
REQ-010 The block SHALL have port mc_wdata  input  32  multi-cycle result data.
REQ-011 The block SHALL have port mc_ready  output  1  queue can accept; a transfer occurs when mc_valid and mc_ready are both high.
REQ-012 The block SHALL have port rf_we  output  1  register file write enable.
REQ-013 The block SHALL have port rf_waddr  output  5  register file write address.
REQ-014 The block SHALL have port rf_wdata  output  32  register file write data.
REQ-015 The block SHALL have port pend_mask  output  32  bit i high when a live queued entry targets register i (bit 0 always low).
REQ-016 The block SHALL have port stall_req  output  1  registered request that the pipeline hold wb_we low next cycle.

Function
REQ-017 Grant SHALL be combinational per cycle: if wb_we=1 then rf_we/rf_waddr/rf_wdata = wb_we/wb_waddr/wb_wdata; else if the queue head is live then rf_* = 1/head addr/head data and the head is popped at the edge; else rf_we=0, rf_waddr=0, rf_wdata=0.
REQ-018 A wb_we=1 with wb_waddr=0 SHALL still take the port (the register file discards it); no queue pop that cycle.
REQ-019 mc_ready SHALL be high when the queue has fewer than DEPTH entries, dead entries included; mc_ready SHALL be computed from registered state only (no dependence on the same-cycle pop).
REQ-020 An accepted mc result with mc_waddr=0 SHALL be consumed and discarded (not enqueued, no pend_mask effect).
REQ-021 An accepted nonzero mc result SHALL be enqueued at the tail, live; it becomes eligible for grant the following cycle (minimum mc-to-rf latency 1 cycle).
REQ-022 Ordering: when wb_we=1 and wb_waddr is nonzero and equal to the address of any live queued entry, each such entry SHALL be marked dead at that edge (the newer pipeline write wins).
REQ-023 An entry being enqueued in the same cycle as a matching wb write SHALL be enqueued live (mc result is newer).
REQ-024 A dead entry at the head SHALL be popped without asserting rf_we, in any cycle, regardless of wb_we.
REQ-025 pend_mask SHALL be the OR over live entries of their one-hot addresses, from registered state.
REQ-026 Starvation counter (3 bits): increments, saturating at STARVE_MAX, each cycle a live head exists and wb_we=1; clears when the head is granted or the queue holds no live entry.
REQ-027 stall_req SHALL be registered high in the cycle after the counter equals STARVE_MAX and a live head exists, and low otherwise; the pipeline contract is wb_we=0 while stall_req=1.
REQ-028 If wb_we=1 while stall_req=1 (contract violation), wb SHALL still win the port; no data loss or reordering.
REQ-029 Simultaneous enqueue and pop on a full queue SHALL not occur (mc_ready=0 when full); enqueue and pop on a non-full queue SHALL both take effect.
REQ-030 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.

Reset
REQ-031 While rst=1, at each rising edge: queue emptied, all entries dead, counter=0, stall_req=0.
REQ-032 While rst=1, outputs SHALL be mc_ready=0, rf_we=0, rf_waddr=0, rf_wdata=0, and pend_mask=0, regardless of inputs; any in-flight mc result is lost.
REQ-033 The first cycle after rst falls SHALL show mc_ready=1 and an empty queue.

Verification
REQ-034 Scenario: wb idle, mc_valid with addr 5, data 0xA5A5A5A5 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xA5A5A5A5; pend_mask bit 5 high for exactly that cycle.
REQ-035 Scenario: wb_we held 1 to addr 3, two mc results (addr 7, addr 8) -> mc_ready=0 after both are accepted; stall_req rises 4 cycles after the first enqueue; after wb_we drops, reg 7 is written, then reg 8, in order.
REQ-036 Scenario: mc result to addr 9 queued while wb_we=1 to addr 9 -> entry killed; pend_mask bit 9 clears; no rf write of the mc data ever occurs.
REQ-037 Scenario: mc_valid to addr 0 -> accepted, no rf write, pend_mask unchanged.
REQ-038 Scenario: rst asserted for 1 cycle with 2 entries queued -> queue empty, all outputs zero during reset, mc_ready=1 the next cycle, no stale write afterwards.
